// File: rtl/sdram_read_arbiter_if.sv
// sdram_read_arbiter_if
//   Bundles the upstream fetch-master bus (m_*) and the downstream SDRAM
//   read bus (s_*) around sdram_read_arbiter.
//   Ports of the bundle:
//     m_read, m_address, m_burstcount   : per-port requests (packed, port i at [i*W +: W])
//     m_waitrequest, m_readdatavalid    : per-port responses
//     m_readdata                        : readdata broadcast to every port
//     s_read, s_address, s_burstcount   : downstream request
//     s_waitrequest, s_readdata,
//     s_readdatavalid                   : downstream response
//   Modports:
//     slave  : the arbiter's view (serves the fetch masters, drives the SDRAM bus)
//     master : the environment's view (fetch masters plus SDRAM controller)
interface sdram_read_arbiter_if #(
  parameter int NUM_PORTS = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int BURST_W   = 8
);
  logic [NUM_PORTS-1:0]         m_read;
  logic [NUM_PORTS*ADDR_W-1:0]  m_address;
  logic [NUM_PORTS*BURST_W-1:0] m_burstcount;
  logic [NUM_PORTS-1:0]         m_waitrequest;
  logic [DATA_W-1:0]            m_readdata;
  logic [NUM_PORTS-1:0]         m_readdatavalid;

  logic                         s_read;
  logic [ADDR_W-1:0]            s_address;
  logic [BURST_W-1:0]           s_burstcount;
  logic                         s_waitrequest;
  logic [DATA_W-1:0]            s_readdata;
  logic                         s_readdatavalid;

  modport slave (
    input  m_read, m_address, m_burstcount,
    output m_waitrequest, m_readdata, m_readdatavalid,
    output s_read, s_address, s_burstcount,
    input  s_waitrequest, s_readdata, s_readdatavalid
  );

  modport master (
    output m_read, m_address, m_burstcount,
    input  m_waitrequest, m_readdata, m_readdatavalid,
    input  s_read, s_address, s_burstcount,
    output s_waitrequest, s_readdata, s_readdatavalid
  );
endinterface

// File: rtl/sdram_read_arbiter.sv
// sdram_read_arbiter
//   Burst-locking round-robin arbiter sharing one Avalon-MM read master
//   (SDRAM) among NUM_PORTS fetch masters. A grant is held until every beat
//   of the accepted burst has returned. fixed_en forces arbitration to the
//   single port fixed_sel.
//   Ports:
//     clk        : clock
//     rst_n      : synchronous active-low reset
//     bus        : sdram_read_arbiter_if.slave (upstream m_* and downstream s_*)
//     fixed_en   : 1 = only port fixed_sel may be granted (sampled in IDLE)
//     fixed_sel  : forced port index
//     busy       : a grant is held (state != IDLE)
//     grant_idx  : currently / last granted port
//     err_sticky : readdatavalid seen outside a burst; cleared only by reset
module sdram_read_arbiter #(
  parameter int NUM_PORTS = 8,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int BURST_W   = 8,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sdram_read_arbiter_if.slave  bus,
  input  logic                 fixed_en,
  input  logic [IDX_W-1:0]     fixed_sel,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 err_sticky
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  localparam logic [IDX_W:0]   NP_EXT   = (IDX_W+1)'(NUM_PORTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [BURST_W:0]     beats_left_q, beats_left_d;
  logic                 err_sticky_q, err_sticky_d;

  logic [ADDR_W-1:0]    addr_arr  [NUM_PORTS];
  logic [BURST_W-1:0]   burst_arr [NUM_PORTS];
  logic [NUM_PORTS-1:0] cand;
  logic                 found;
  logic [IDX_W-1:0]     pick;
  logic [NUM_PORTS-1:0] wr_vec;
  logic [NUM_PORTS-1:0] rdv_vec;
  logic [BURST_W-1:0]   sel_burst;
  logic [DATA_W-1:0]    rdata;

  // Unpack the per-port address / burstcount buses.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    assign addr_arr[gi]  = bus.m_address[gi*ADDR_W +: ADDR_W];
    assign burst_arr[gi] = bus.m_burstcount[gi*BURST_W +: BURST_W];
  end

  // Candidate set: all requesters, or only the forced port.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand[i] = bus.m_read[i] && (!fixed_en || (fixed_sel == IDX_W'(i)));
    end
  end

  // Round-robin search starting at rr_ptr; index wraps modulo NUM_PORTS,
  // which need not be a power of two.
  always_comb begin : rr_search
    logic [IDX_W:0] idx_ext;
    found   = 1'b0;
    pick    = '0;
    idx_ext = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx_ext = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (idx_ext >= NP_EXT) begin
        idx_ext = idx_ext - NP_EXT;
      end
      if (!found && cand[idx_ext[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = idx_ext[IDX_W-1:0];
      end
    end
  end

  assign sel_burst = burst_arr[grant_idx_q];

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_idx_d  = grant_idx_q;
    beats_left_d = beats_left_q;
    // Any beat outside a burst is a protocol error and is never forwarded.
    err_sticky_d = err_sticky_q || (bus.s_readdatavalid && (state_q != DATA));
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_idx_d = pick;
          state_d     = ADDR;
        end
      end
      ADDR: begin
        if (!bus.s_waitrequest) begin
          // A zero burstcount is served as a single beat.
          beats_left_d = (sel_burst == '0) ? (BURST_W+1)'(1) : {1'b0, sel_burst};
          state_d      = DATA;
        end
      end
      DATA: begin
        if (bus.s_readdatavalid) begin
          beats_left_d = beats_left_q - 1'b1;
          if (beats_left_q == (BURST_W+1)'(1)) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      grant_idx_q  <= '0;
      beats_left_q <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_idx_q  <= grant_idx_d;
      beats_left_q <= beats_left_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Per-port responses: only the granted port ever sees waitrequest low
  // (in ADDR) or readdatavalid high (in DATA).
  always_comb begin
    wr_vec  = '1;
    rdv_vec = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        wr_vec[i]  = !((state_q == ADDR) && !bus.s_waitrequest);
        rdv_vec[i] = (state_q == DATA) && bus.s_readdatavalid;
      end
    end
  end

  assign rdata               = bus.s_readdata;
  assign bus.m_readdata      = rdata;
  assign bus.m_waitrequest   = wr_vec;
  assign bus.m_readdatavalid = rdv_vec;
  assign bus.s_read          = (state_q == ADDR);
  assign bus.s_address       = addr_arr[grant_idx_q];
  assign bus.s_burstcount    = sel_burst;

  assign busy       = (state_q != IDLE);
  assign grant_idx  = grant_idx_q;
  assign err_sticky = err_sticky_q;

endmodule
